// File: rtl/mips_loader_pkg.sv
// Shared types and constants for the MIPS instruction-memory loader.
// The CHK state only exists when MIPS_LOADER_CHECKSUM_EN is defined.
package mips_loader_pkg;

   localparam int HDR_BYTES      = 2;
   localparam int BYTES_PER_WORD = 4;

   localparam logic [1:0] LAST_BYTE_IDX = 2'(BYTES_PER_WORD - 1);

   typedef enum logic [2:0] {
      ST_HDR_HI = 3'd0,
      ST_HDR_LO = 3'd1,
      ST_DATA   = 3'd2,
`ifdef MIPS_LOADER_CHECKSUM_EN
      ST_CHK    = 3'd3,
`endif
      ST_DONE   = 3'd4,
      ST_ERROR  = 3'd5
   } loader_state_e;

   function automatic logic [7:0] xor_accum(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction

endpackage

// File: rtl/loader_word_packer.sv
// Packs stream bytes MSB-first into 32-bit words; flags the byte that completes a word.
module loader_word_packer
   import mips_loader_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        load,
   input  logic [7:0]  byte_in,
   output logic        word_done,
   output logic [31:0] word
);

   logic [23:0] shift_r;
   logic [1:0]  cnt_r;

   // The completed word is formed combinationally so the caller can register it on the 4th byte.
   always_comb begin
      word_done = load && (cnt_r == LAST_BYTE_IDX);
      word      = {shift_r, byte_in};
   end

   // Shift in one byte per accepted load; the counter wraps naturally every four bytes.
   always_ff @(posedge clock) begin
      if (reset) begin
         shift_r <= 24'd0;
         cnt_r   <= 2'd0;
      end else if (load) begin
         shift_r <= word[23:0];
         cnt_r   <= cnt_r + 2'd1;
      end else begin
         shift_r <= shift_r;
         cnt_r   <= cnt_r;
      end
   end

endmodule

// File: rtl/mips_imem_loader.sv
// Boot-time instruction-memory loader: byte stream -> big-endian words, CPU held in reset until done.
// Define MIPS_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the payload.
module mips_imem_loader
   import mips_loader_pkg::*;
#(
   parameter int ADDR_W = 6
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [7:0]  in_byte,
   output logic        in_ready,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        cpu_reset,
   output logic        done,
   output logic        err
);

   localparam int CNT_W = 8 * HDR_BYTES;
   localparam logic [CNT_W:0]   CAP_ONE  = {{CNT_W{1'b0}}, 1'b1};
   localparam logic [CNT_W:0]   CAPACITY = CAP_ONE << ADDR_W;
   localparam logic [CNT_W-1:0] IDX_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef MIPS_LOADER_CHECKSUM_EN
   localparam loader_state_e ST_AFTER_DATA = ST_CHK;
`else
   localparam loader_state_e ST_AFTER_DATA = ST_DONE;
`endif

   loader_state_e    state_r, state_nxt_s;
   logic [CNT_W-1:0] count_r, word_idx_r, hdr_n_s;
   logic             in_ready_r, imem_we_r, cpu_reset_r, done_r, err_r;
   logic [31:0]      imem_addr_r, imem_wdata_r;
   logic             accept_s, load_s, word_done_s, last_word_s;
   logic [31:0]      word_s;
`ifdef MIPS_LOADER_CHECKSUM_EN
   logic [7:0]       xor_r;
`endif

   assign in_ready   = in_ready_r;
   assign imem_we    = imem_we_r;
   assign imem_addr  = imem_addr_r;
   assign imem_wdata = imem_wdata_r;
   assign cpu_reset  = cpu_reset_r;
   assign done       = done_r;
   assign err        = err_r;

   // Handshake decode and the word count formed from the high byte plus the byte on the bus.
   always_comb begin
      accept_s    = in_valid && in_ready_r;
      load_s      = accept_s && (state_r == ST_DATA);
      hdr_n_s     = {count_r[CNT_W-9:0], in_byte};
      last_word_s = (word_idx_r == (count_r - IDX_ONE));
   end

   loader_word_packer u_packer (
      .clock     (clock),
      .reset     (reset),
      .load      (load_s),
      .byte_in   (in_byte),
      .word_done (word_done_s),
      .word      (word_s)
   );

   // Next-state logic; only accepted bytes move the FSM, so stalls hold state.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_HDR_HI: begin
            if (accept_s) state_nxt_s = ST_HDR_LO;
            else          state_nxt_s = state_r;
         end
         ST_HDR_LO: begin
            if (!accept_s)                          state_nxt_s = state_r;
            else if ({1'b0, hdr_n_s} > CAPACITY)    state_nxt_s = ST_ERROR;
            else if (hdr_n_s == {CNT_W{1'b0}})      state_nxt_s = ST_AFTER_DATA;
            else                                    state_nxt_s = ST_DATA;
         end
         ST_DATA: begin
            if (word_done_s && last_word_s) state_nxt_s = ST_AFTER_DATA;
            else                            state_nxt_s = state_r;
         end
`ifdef MIPS_LOADER_CHECKSUM_EN
         ST_CHK: begin
            if (!accept_s)            state_nxt_s = state_r;
            else if (in_byte == xor_r) state_nxt_s = ST_DONE;
            else                      state_nxt_s = ST_ERROR;
         end
`endif
         ST_DONE:  state_nxt_s = ST_DONE;
         ST_ERROR: state_nxt_s = ST_ERROR;
         default:  state_nxt_s = ST_ERROR;
      endcase
   end

   // State, header count, write port and status registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r      <= ST_HDR_HI;
         count_r      <= {CNT_W{1'b0}};
         word_idx_r   <= {CNT_W{1'b0}};
         in_ready_r   <= 1'b1;
         imem_we_r    <= 1'b0;
         imem_addr_r  <= 32'd0;
         imem_wdata_r <= 32'd0;
         cpu_reset_r  <= 1'b1;
         done_r       <= 1'b0;
         err_r        <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         in_ready_r  <= (state_nxt_s != ST_DONE) && (state_nxt_s != ST_ERROR);
         done_r      <= (state_nxt_s == ST_DONE);
         err_r       <= (state_nxt_s == ST_ERROR);
         // Trails done by one cycle so the final write lands before the first fetch.
         cpu_reset_r <= ~done_r;
         imem_we_r   <= word_done_s;
         if (accept_s && ((state_r == ST_HDR_HI) || (state_r == ST_HDR_LO))) begin
            count_r <= hdr_n_s;
         end else begin
            count_r <= count_r;
         end
         if (word_done_s) begin
            imem_addr_r  <= 32'({word_idx_r, 2'b00});
            imem_wdata_r <= word_s;
            word_idx_r   <= word_idx_r + IDX_ONE;
         end else begin
            imem_addr_r  <= imem_addr_r;
            imem_wdata_r <= imem_wdata_r;
            word_idx_r   <= word_idx_r;
         end
      end
   end

`ifdef MIPS_LOADER_CHECKSUM_EN
   // Running XOR over payload bytes only; header bytes never reach the packer.
   always_ff @(posedge clock) begin
      if (reset)       xor_r <= 8'd0;
      else if (load_s) xor_r <= xor_accum(xor_r, in_byte);
      else             xor_r <= xor_r;
   end
`endif

endmodule

// File: tb/tb_mips_imem_loader.sv
// Directed self-checking bench for mips_imem_loader (default ADDR_W=6).
// Honours MIPS_LOADER_CHECKSUM_EN in the same way as the RTL.
module tb_mips_imem_loader;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic [7:0]  in_byte = 8'h00;
   logic        in_ready, imem_we, cpu_reset, done, err;
   logic [31:0] imem_addr, imem_wdata;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   logic [31:0] wr_addr [0:255];
   logic [31:0] wr_data [0:255];
   int wr_count, lat_err, done_cyc, fall_cyc, err_cyc, last_acc_cyc, last_wr_cyc;
   logic prev_acc;

   mips_imem_loader #(.ADDR_W(6)) dut (
      .clock      (clock),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_byte    (in_byte),
      .in_ready   (in_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_reset  (cpu_reset),
      .done       (done),
      .err        (err)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc++;

   // Observe on the falling edge; a write must immediately follow an accepted byte.
   always @(negedge clock) begin
      if (imem_we) begin
         if (wr_count < 256) begin
            wr_addr[wr_count] = imem_addr;
            wr_data[wr_count] = imem_wdata;
         end
         wr_count++;
         last_wr_cyc = cyc;
         if (!prev_acc) lat_err++;
      end
      if (done && done_cyc < 0) done_cyc = cyc;
      if (!cpu_reset && fall_cyc < 0) fall_cyc = cyc;
      if (err && err_cyc < 0) err_cyc = cyc;
      prev_acc = in_valid & in_ready;
      if (prev_acc) last_acc_cyc = cyc;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(posedge clock); #1;
      reset = 1'b1;
      in_valid = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      wr_count = 0; lat_err = 0; done_cyc = -1; fall_cyc = -1; err_cyc = -1;
      last_acc_cyc = -1; last_wr_cyc = -1; prev_acc = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      in_valid = 1'b0;
      repeat (gap) @(posedge clock);
      if (gap > 0) #1;
      in_valid = 1'b1;
      in_byte  = b;
      n = 0;
      while (!in_ready && n < 20) begin
         @(posedge clock); #1;
         n++;
      end
      if (!in_ready) check("ready_timeout", {31'd0, in_ready}, 32'd1);
      @(posedge clock); #1;
      in_valid = 1'b0;
   endtask

   task automatic send_stream(input logic [7:0] s[$], input int gap);
      foreach (s[i]) send_byte(s[i], gap);
      repeat (3) @(posedge clock);
      #1;
   endtask

   function automatic logic [7:0] payload_xor(input logic [7:0] s[$]);
      logic [7:0] x = 8'h00;
      for (int i = 2; i < s.size(); i++) x ^= s[i];
      return x;
   endfunction

   task automatic check_two_words(input string tag);
      check({tag, "_count"}, 32'(wr_count), 32'd2);
      check({tag, "_addr0"}, wr_addr[0], 32'h0000_0000);
      check({tag, "_data0"}, wr_data[0], 32'h2008_0005);
      check({tag, "_addr1"}, wr_addr[1], 32'h0000_0004);
      check({tag, "_data1"}, wr_data[1], 32'hAC08_0004);
      check({tag, "_latency"}, 32'(lat_err), 32'd0);
      check({tag, "_done"}, {31'd0, done}, 32'd1);
      check({tag, "_err"}, {31'd0, err}, 32'd0);
      check({tag, "_cpu_reset"}, {31'd0, cpu_reset}, 32'd0);
      check({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
      check({tag, "_fall_after_done"}, 32'(fall_cyc), 32'(done_cyc + 1));
`ifdef MIPS_LOADER_CHECKSUM_EN
      check({tag, "_done_timing"}, 32'(done_cyc), 32'(last_acc_cyc + 1));
`else
      check({tag, "_done_timing"}, 32'(done_cyc), 32'(last_wr_cyc));
`endif
   endtask

   initial begin
      logic [7:0] s[$];
      logic [7:0] w;

      do_reset();
      check("rst_ready", {31'd0, in_ready}, 32'd1);
      check("rst_we", {31'd0, imem_we}, 32'd0);
      check("rst_addr", imem_addr, 32'd0);
      check("rst_wdata", imem_wdata, 32'd0);
      check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);

      // N=2, back-to-back bytes.
      s = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h04};
`ifdef MIPS_LOADER_CHECKSUM_EN
      s.push_back(payload_xor(s));
`endif
      send_stream(s, 0);
      check_two_words("cont");

      // Same stream with a one-cycle gap before every byte.
      do_reset();
      send_stream(s, 1);
      check_two_words("gap");

      // N=0.
      do_reset();
      s = '{8'h00, 8'h00};
`ifdef MIPS_LOADER_CHECKSUM_EN
      s.push_back(8'h00);
`endif
      send_stream(s, 0);
      check("n0_count", 32'(wr_count), 32'd0);
      check("n0_done", {31'd0, done}, 32'd1);
      check("n0_done_timing", 32'(done_cyc), 32'(last_acc_cyc + 1));
      check("n0_fall", 32'(fall_cyc), 32'(done_cyc + 1));

      // N=65 exceeds a 64-word memory.
      do_reset();
      s = '{8'h00, 8'h41};
      send_stream(s, 0);
      check("ovf_err", {31'd0, err}, 32'd1);
      check("ovf_err_timing", 32'(err_cyc), 32'(last_acc_cyc + 1));
      check("ovf_ready", {31'd0, in_ready}, 32'd0);
      check("ovf_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      check("ovf_done", {31'd0, done}, 32'd0);
      check("ovf_count", 32'(wr_count), 32'd0);

      // N=64 fills memory exactly.
      do_reset();
      s = '{8'h00, 8'h40};
      for (int i = 0; i < 64; i++) begin
         w = 8'(i);
         s.push_back(w);
         s.push_back(8'hA5);
         s.push_back(~w);
         s.push_back(8'h3C);
      end
`ifdef MIPS_LOADER_CHECKSUM_EN
      s.push_back(payload_xor(s));
`endif
      send_stream(s, 0);
      check("full_count", 32'(wr_count), 32'd64);
      check("full_last_addr", wr_addr[63], 32'h0000_00FC);
      check("full_last_data", wr_data[63], 32'h3FA5_C03C);
      check("full_done", {31'd0, done}, 32'd1);
      check("full_err", {31'd0, err}, 32'd0);

`ifdef MIPS_LOADER_CHECKSUM_EN
      // Bad checksum: the word is still written, but the load fails.
      do_reset();
      s = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
      send_stream(s, 0);
      check("chk_err", {31'd0, err}, 32'd1);
      check("chk_done", {31'd0, done}, 32'd0);
      check("chk_count", 32'(wr_count), 32'd1);
      check("chk_data", wr_data[0], 32'h0000_0000);
      check("chk_cpu_reset", {31'd0, cpu_reset}, 32'd1);
`endif

      // Reset after three payload bytes, then a fresh single-word load.
      do_reset();
      s = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33};
      send_stream(s, 0);
      do_reset();
      s = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
`ifdef MIPS_LOADER_CHECKSUM_EN
      s.push_back(payload_xor(s));
`endif
      send_stream(s, 0);
      check("mid_count", 32'(wr_count), 32'd1);
      check("mid_addr", wr_addr[0], 32'h0000_0000);
      check("mid_data", wr_data[0], 32'hDEAD_BEEF);
      check("mid_done", {31'd0, done}, 32'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
